mux_select_sequencer: RTL and testbench

- Controller that shares one 2:1 select-mux output path between two requesters.
- Owns the mux `select` line and an output-enable.
- Arbitrates round-robin with a bounded hold time.
- Applies break-before-make blanking: out_en stays low for SETTLE_CYCLES whenever select changes, so downstream logic never samples a switching (glitching) mux.

---
 rtl/mux_select_sequencer_pkg.sv | 20 ++
 rtl/settle_timer.sv | 36 +++
 rtl/mux_select_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mux_select_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_select_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_select_sequencer_pkg
// Description : Shared state encoding and owner constants for the
//               mux select sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_select_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_GRANT = 2'd2
    } seq_state_t;

    localparam logic OWNER0 = 1'b0;
    localparam logic OWNER1 = 1'b1;

endpackage : mux_select_sequencer_pkg
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : settle_timer
// Description : Loadable down-counter with zero flag; times the blanking
//               window that follows each select change.
// Revision    : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] c_LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Saturates at zero so an idle timer never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/mux_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_select_sequencer
// Description : Round-robin owner of a shared 2:1 mux with bounded hold time
//               and break-before-make blanking on every select change.
//               Optional counters: MUX_SELECT_SEQUENCER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_select_sequencer
    import mux_select_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3,
    parameter int MAX_HOLD      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    output logic        select,
    output logic        out_en,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy
`ifdef MUX_SELECT_SEQUENCER_STATS_EN
    ,
    output logic [15:0] switch_count,
    output logic [15:0] preempt_count
`endif
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] c_HOLD_LAST = HW'(MAX_HOLD - 1);

    seq_state_t     r_state;
    seq_state_t     w_state_nxt;
    logic           r_sel;
    logic           w_sel_nxt;
    logic           r_last;
    logic           w_last_nxt;
    logic [HW-1:0]  r_hold;
    logic [HW-1:0]  w_hold_nxt;
    logic           w_load;
    logic           w_preempt;
    logic           w_settle_zero;
    logic           w_req_own;
    logic           w_req_oth;
    logic           w_target;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .zero (w_settle_zero)
    );

    assign w_req_own = r_sel ? req1 : req0;
    assign w_req_oth = r_sel ? req0 : req1;
    assign w_target  = (req0 && req1) ? ~r_last : (req1 ? OWNER1 : OWNER0);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        w_load      = 1'b0;
        w_preempt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    if (w_target == r_sel) begin
                        w_state_nxt = S_GRANT;
                        w_hold_nxt  = '0;
                    end else begin
                        w_sel_nxt   = w_target;
                        w_load      = 1'b1;
                        w_state_nxt = S_BLANK;
                    end
                end
            end
            S_BLANK: begin
                if (w_settle_zero) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = w_req_own ? S_GRANT : S_IDLE;
                end
            end
            S_GRANT: begin
                if (!w_req_own) begin
                    w_last_nxt = r_sel;
                    if (w_req_oth) begin
                        w_sel_nxt   = ~r_sel;
                        w_load      = 1'b1;
                        w_state_nxt = S_BLANK;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_req_oth && (r_hold == c_HOLD_LAST)) begin
                    w_last_nxt  = r_sel;
                    w_sel_nxt   = ~r_sel;
                    w_load      = 1'b1;
                    w_preempt   = 1'b1;
                    w_state_nxt = S_BLANK;
                end else if (r_hold != c_HOLD_LAST) begin
                    // Parked at the limit so an uncontested owner never wraps
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sel   <= OWNER0;
            r_last  <= OWNER1;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Output stage mirrors the current state, keeping req off every output path
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            select <= 1'b0;
            out_en <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            select <= r_sel;
            out_en <= (r_state == S_GRANT);
            gnt0   <= (r_state == S_GRANT) && !r_sel;
            gnt1   <= (r_state == S_GRANT) && r_sel;
            busy   <= (r_state != S_IDLE);
        end
    end

`ifdef MUX_SELECT_SEQUENCER_STATS_EN
    logic [15:0] r_switch_count;
    logic [15:0] r_preempt_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_switch_count  <= '0;
            r_preempt_count <= '0;
        end else begin
            if ((w_sel_nxt != r_sel) && (r_switch_count != 16'hFFFF)) begin
                r_switch_count <= r_switch_count + 16'd1;
            end
            if (w_preempt && (r_preempt_count != 16'hFFFF)) begin
                r_preempt_count <= r_preempt_count + 16'd1;
            end
        end
    end

    assign switch_count  = r_switch_count;
    assign preempt_count = r_preempt_count;
`endif

endmodule : mux_select_sequencer
`default_nettype wire

// File: tb/tb_mux_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_select_sequencer
// Description : Self-checking bench: directed vector table, async-reset and
//               statistics sequences, then random requests against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_select_sequencer;

    localparam int SETTLE = 3;
    localparam int HOLD   = 4;
    localparam int PH_IDLE  = 0;
    localparam int PH_BLANK = 1;
    localparam int PH_GRANT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic select, out_en, gnt0, gnt1, busy;
`ifdef MUX_SELECT_SEQUENCER_STATS_EN
    logic [15:0] switch_count, preempt_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mux_select_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .MAX_HOLD      (HOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .select (select),
        .out_en (out_en),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .busy   (busy)
`ifdef MUX_SELECT_SEQUENCER_STATS_EN
        ,
        .switch_count  (switch_count),
        .preempt_count (preempt_count)
`endif
    );

    always #5 clk = ~clk;

    // Expected output vector packing: {select, out_en, gnt0, gnt1, busy}
    typedef struct {
        logic       do_rst;
        logic       r0;
        logic       r1;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: phase, owner and cycle counters as plain integers
    int   m_phase, m_blank_left, m_held, m_switches, m_preempts;
    logic m_sel, m_last;
    logic [4:0] e_out;

    function automatic logic [4:0] outs();
        return {select, out_en, gnt0, gnt1, busy};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE; m_sel = 1'b0; m_last = 1'b1;
        m_blank_left = 0; m_held = 0; m_switches = 0; m_preempts = 0;
    endtask

    task automatic model_switch(input logic is_preempt);
        m_sel = ~m_sel;
        m_phase = PH_BLANK;
        m_blank_left = SETTLE;
        if (m_switches < 65535) m_switches++;
        if (is_preempt && m_preempts < 65535) m_preempts++;
    endtask

    // Captures what the outputs will show after this edge, then advances the model
    task automatic model_edge(input logic r0, input logic r1);
        logic own, oth, tgt;
        e_out = {m_sel, m_phase == PH_GRANT, (m_phase == PH_GRANT) && !m_sel,
                 (m_phase == PH_GRANT) && m_sel, m_phase != PH_IDLE};
        own = m_sel ? r1 : r0;
        oth = m_sel ? r0 : r1;
        if (m_phase == PH_IDLE) begin
            if (r0 || r1) begin
                tgt = (r0 && r1) ? ~m_last : r1;
                if (tgt == m_sel) begin
                    m_phase = PH_GRANT; m_held = 0;
                end else begin
                    model_switch(1'b0);
                end
            end
        end else if (m_phase == PH_BLANK) begin
            m_blank_left--;
            if (m_blank_left == 0) begin
                m_held = 0;
                m_phase = own ? PH_GRANT : PH_IDLE;
            end
        end else begin
            if (!own) begin
                m_last = m_sel;
                if (oth) model_switch(1'b0);
                else m_phase = PH_IDLE;
            end else if (oth && (m_held + 1 >= HOLD)) begin
                m_last = m_sel;
                model_switch(1'b1);
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {11'd0, outs()}, 16'd0);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic add(input logic d, input logic a, input logic b, input logic [4:0] e, input string n);
        vec_t v;
        v.do_rst = d; v.r0 = a; v.r1 = b; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        logic prev_sel, prev_en;

        // Direct grant, select already matching
        add(1, 1, 0, 5'b00000, "s1_e0");
        add(0, 1, 0, 5'b01101, "s1_gnt0");
        add(0, 0, 0, 5'b01101, "s1_drop");
        add(0, 0, 0, 5'b00000, "s1_idle");
        // Switch to requester 1 with blanking
        add(1, 0, 1, 5'b00000, "s2_e0");
        for (int i = 0; i < SETTLE; i++) add(0, 0, 1, 5'b10001, "s2_blank");
        add(0, 0, 1, 5'b11011, "s2_gnt1");
        add(0, 0, 0, 5'b11011, "s2_drop");
        add(0, 0, 0, 5'b10000, "s2_idle_sel1");
        // Both requesting: alternate with bounded hold
        add(1, 1, 1, 5'b00000, "s3_e0");
        for (int i = 0; i < HOLD; i++)   add(0, 1, 1, 5'b01101, "s3_gnt0");
        for (int i = 0; i < SETTLE; i++) add(0, 1, 1, 5'b10001, "s3_blank1");
        for (int i = 0; i < HOLD; i++)   add(0, 1, 1, 5'b11011, "s3_gnt1");
        for (int i = 0; i < SETTLE; i++) add(0, 1, 1, 5'b00001, "s3_blank0");
        add(0, 1, 1, 5'b01101, "s3_gnt0_again");
        // Request dropped mid-blank: no gnt1 pulse
        add(1, 0, 1, 5'b00000, "s4_e0");
        add(0, 0, 1, 5'b10001, "s4_blank1");
        add(0, 0, 1, 5'b10001, "s4_blank2");
        add(0, 0, 0, 5'b10001, "s4_blank3");
        add(0, 0, 0, 5'b10000, "s4_idle");
        add(0, 0, 0, 5'b10000, "s4_idle_hold");

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) apply_reset();
            req0 = vecs[i].r0;
            req1 = vecs[i].r1;
            @(posedge clk);
            #1;
            check(vecs[i].name, {11'd0, outs()}, {11'd0, vecs[i].exp});
        end

        // Asynchronous reset asserted between edges during a grant
        apply_reset();
        req1 = 1'b1;
        repeat (SETTLE + 2) @(posedge clk);
        #1;
        check("async_pre_gnt1", {11'd0, outs()}, 16'b11011);
        #2 rst = 1'b0;
        #1;
        check("async_immediate", {11'd0, outs()}, 16'd0);
        req1 = 1'b0;
        req0 = 1'b1;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("async_rel_e0", {11'd0, outs()}, 16'd0);
        @(posedge clk); #1;
        check("async_rel_gnt0", {11'd0, outs()}, 16'b01101);

`ifdef MUX_SELECT_SEQUENCER_STATS_EN
        apply_reset();
        check("stats_reset_sw", switch_count, 16'd0);
        check("stats_reset_pre", preempt_count, 16'd0);
        req0 = 1'b1; req1 = 1'b1;
        repeat (3 * (HOLD + SETTLE) - 2) @(posedge clk);
        #1;
        check("stats_preempt", preempt_count, 16'd3);
        check("stats_switch", switch_count, 16'd3);
`endif

        // Random request traffic against the model
        apply_reset();
        prev_sel = select;
        prev_en  = out_en;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) req0 = ~req0;
            if ($urandom_range(7) == 0) req1 = ~req1;
            model_edge(req0, req1);
            @(posedge clk);
            #1;
            check("rand_outputs", {11'd0, outs()}, {11'd0, e_out});
            check("rand_gnt_excl", {15'd0, gnt0 && gnt1}, 16'd0);
            if (prev_en && out_en) check("rand_sel_stable", {15'd0, select}, {15'd0, prev_sel});
`ifdef MUX_SELECT_SEQUENCER_STATS_EN
            check("rand_switch_cnt", switch_count, 16'(m_switches));
            check("rand_preempt_cnt", preempt_count, 16'(m_preempts));
`endif
            prev_sel = select;
            prev_en  = out_en;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_select_sequencer
`default_nettype wire
